// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register-file write port between two writeback sources.
//   Source A is the ALU/pipeline writeback and source B is the load/multi-cycle
//   unit. Each source uses a valid/ready handshake, and grants alternate
//   round-robin when both sources compete. Each accepted write is launched one
//   cycle later as a registered enable/address/data triple. Writes to the
//   hard-wired zero register are accepted but are not enabled.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   stall      : suppresses all grants this cycle
//   a_valid/a_addr/a_data, a_ready : source A handshake (ready is combinational)
//   b_valid/b_addr/b_data, b_ready : source B handshake (ready is combinational)
//   wr_en/wr_addr/wr_data          : registered write triple to the register file
//   last_grant : registered; 0 = A was granted most recently, 1 = B
module regfile_wr_arbiter #(
  parameter int WIDTH    = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             last_grant
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic xfer_a_p0;
  logic xfer_b_p0;

  // Stage p0: combinational grant. On a tie, the source not granted last wins.
  // Readies depend only on stall, the valids and the pointer, never on addr/data.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!stall) begin
      if (a_valid && b_valid) begin
        if (last_grant) a_ready = 1'b1;
        else            b_ready = 1'b1;
      end else if (a_valid) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  assign xfer_a_p0 = a_valid && a_ready;
  assign xfer_b_p0 = b_valid && b_ready;

  // Stage p1: registered write triple. A zero-register write still moves the
  // pointer and loads addr/data, but leaves the enable low.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
    end else if (xfer_a_p0) begin
      wr_en      <= (a_addr != ZERO_ADDR);
      wr_addr    <= a_addr;
      wr_data    <= a_data;
      last_grant <= 1'b0;
    end else if (xfer_b_p0) begin
      wr_en      <= (b_addr != ZERO_ADDR);
      wr_addr    <= b_addr;
      wr_data    <= b_data;
      last_grant <= 1'b1;
    end else begin
      wr_en      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: scenario tasks drive the two sources and
// push the expected write triple into a scoreboard queue when a grant is
// expected; the entry is popped and compared after the following clock edge.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        last_grant;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        lg;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  regfile_wr_arbiter #(.WIDTH(64), .AW(5), .ZERO_REG(31)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [63:0] bd,
                       input logic st);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    stall   = st;
  endtask

  task automatic test_reset();
    exp_t got;
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    #1;
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== {1'b0, 5'd0, 64'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got en=%0b addr=%0d data=%0h lg=%0b exp en=0 addr=0 data=0 lg=1",
               wr_en, wr_addr, wr_data, last_grant);
    end
    checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle_ready got a=%0b b=%0b exp a=0 b=0", a_ready, b_ready);
    end
  endtask

  task automatic test_a_alone();
    exp_t e;
    exp_t got;
    drive(1'b1, 5'd3, 64'd5000, 1'b0, 5'd0, 64'd0, 1'b0);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      failures++;
      $display("FAIL a_alone_ready got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready);
    end
    sb.push_back('{en: 1'b1, addr: 5'd3, data: 64'd5000, lg: 1'b0});
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    e = sb.pop_front();
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL a_alone_write got en=%0b addr=%0d data=%0d lg=%0b exp en=%0b addr=%0d data=%0d lg=%0b",
               wr_en, wr_addr, wr_data, last_grant, e.en, e.addr, e.data, e.lg);
    end
    tick();
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== {1'b0, 5'd3, 64'd5000, 1'b0}) begin
      failures++;
      $display("FAIL a_alone_after got en=%0b addr=%0d data=%0d lg=%0b exp en=0 addr=3 data=5000 lg=0",
               wr_en, wr_addr, wr_data, last_grant);
    end
  endtask

  task automatic test_b_alone();
    exp_t e;
    exp_t got;
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd30, 64'hDEAD_BEEF_0123_4567, 1'b0);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b_alone_ready got a=%0b b=%0b exp a=0 b=1", a_ready, b_ready);
    end
    sb.push_back('{en: 1'b1, addr: 5'd30, data: 64'hDEAD_BEEF_0123_4567, lg: 1'b1});
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    e = sb.pop_front();
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL b_alone_write got en=%0b addr=%0d data=%0h lg=%0b exp en=%0b addr=%0d data=%0h lg=%0b",
               wr_en, wr_addr, wr_data, last_grant, e.en, e.addr, e.data, e.lg);
    end
    // Put the pointer back on A so the zero-register case really moves it.
    drive(1'b1, 5'd4, 64'd44, 1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    checks++;
    if ({wr_en, wr_addr, last_grant} !== {1'b1, 5'd4, 1'b0}) begin
      failures++;
      $display("FAIL a_restore got en=%0b addr=%0d lg=%0b exp en=1 addr=4 lg=0", wr_en, wr_addr, last_grant);
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    exp_t got;
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'd999, 1'b0);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      failures++;
      $display("FAIL zero_reg_ready got a=%0b b=%0b exp a=0 b=1", a_ready, b_ready);
    end
    sb.push_back('{en: 1'b0, addr: 5'd31, data: 64'd999, lg: 1'b1});
    tick();
    e = sb.pop_front();
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL zero_reg_write got en=%0b addr=%0d data=%0d lg=%0b exp en=%0b addr=%0d data=%0d lg=%0b",
               wr_en, wr_addr, wr_data, last_grant, e.en, e.addr, e.data, e.lg);
    end
    // A tie now favours A; both valids then drop with no transfer.
    drive(1'b1, 5'd1, 64'd1010, 1'b1, 5'd2, 64'd2020, 1'b0);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      failures++;
      $display("FAIL zero_reg_tie got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready);
    end
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    tick();
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== {1'b0, 5'd31, 64'd999, 1'b1}) begin
      failures++;
      $display("FAIL drop_valid_hold got en=%0b addr=%0d data=%0d lg=%0b exp en=0 addr=31 data=999 lg=1",
               wr_en, wr_addr, wr_data, last_grant);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    logic a_turn;
    drive(1'b1, 5'd1, 64'd1010, 1'b1, 5'd2, 64'd2020, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a_turn = (i % 2 == 0);
      #1;
      checks++;
      if ({a_ready, b_ready} !== {a_turn, ~a_turn}) begin
        failures++;
        $display("FAIL b2b_ready[%0d] got a=%0b b=%0b exp a=%0b b=%0b", i, a_ready, b_ready, a_turn, ~a_turn);
      end
      if (a_turn) sb.push_back('{en: 1'b1, addr: 5'd1, data: 64'd1010, lg: 1'b0});
      else        sb.push_back('{en: 1'b1, addr: 5'd2, data: 64'd2020, lg: 1'b1});
      tick();
      e = sb.pop_front();
      got = {wr_en, wr_addr, wr_data, last_grant};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL b2b_write[%0d] got en=%0b addr=%0d data=%0d lg=%0b exp en=%0b addr=%0d data=%0d lg=%0b",
                 i, wr_en, wr_addr, wr_data, last_grant, e.en, e.addr, e.data, e.lg);
      end
    end
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
  endtask

  task automatic test_stall();
    exp_t e;
    exp_t got;
    drive(1'b1, 5'd5, 64'd55, 1'b1, 5'd6, 64'd66, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
        failures++;
        $display("FAIL stall_ready[%0d] got a=%0b b=%0b exp a=0 b=0", i, a_ready, b_ready);
      end
      tick();
      checks++;
      if ({wr_en, last_grant} !== 2'b01) begin
        failures++;
        $display("FAIL stall_out[%0d] got en=%0b lg=%0b exp en=0 lg=1", i, wr_en, last_grant);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      failures++;
      $display("FAIL stall_release_ready got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready);
    end
    sb.push_back('{en: 1'b1, addr: 5'd5, data: 64'd55, lg: 1'b0});
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    e = sb.pop_front();
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL stall_release_write got en=%0b addr=%0d data=%0d lg=%0b exp en=%0b addr=%0d data=%0d lg=%0b",
               wr_en, wr_addr, wr_data, last_grant, e.en, e.addr, e.data, e.lg);
    end
  endtask

  task automatic test_reset_xfer();
    exp_t got;
    drive(1'b1, 5'd7, 64'd77, 1'b0, 5'd0, 64'd0, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_xfer_ready got a=%0b exp a=1", a_ready);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    got = {wr_en, wr_addr, wr_data, last_grant};
    checks++;
    if (got !== {1'b0, 5'd0, 64'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_xfer_out got en=%0b addr=%0d data=%0d lg=%0b exp en=0 addr=0 data=0 lg=1",
               wr_en, wr_addr, wr_data, last_grant);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    test_reset();
    test_a_alone();
    test_b_alone();
    test_zero_reg();
    test_back_to_back();
    test_stall();
    test_reset_xfer();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got left=%0d exp left=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single 64-bit register-file write port between two writeback sources: A (ALU/pipeline writeback) and B (load/multi-cycle unit). Each source uses a valid/ready handshake. Grants alternate round-robin on contention. Each accepted write is launched as a registered write-enable/address/data triple, one cycle later, which drives the enable (`e`) of the addressed `register_v` in the register file. Writes to the hard-wired zero register are accepted and discarded.

## Interface
- `WIDTH`, 64, data width of each register.
- `AW`, 5, register address width (32 registers).
- `ZERO_REG`, 31, address of the read-as-zero register; writes to it are dropped.

- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: when 1, no grants are issued this cycle.
- `a_valid` input 1: source A presents a write.
- `a_addr` input AW: source A destination register.
- `a_data` input WIDTH: source A write data.
- `a_ready` output 1: combinational grant to A.
- `b_valid` input 1: source B presents a write.
- `b_addr` input AW: source B destination register.
- `b_data` input WIDTH: source B write data.
- `b_ready` output 1: combinational grant to B.
- `wr_en` output 1: registered write enable to the register file (decoded to per-register `e`).
- `wr_addr` output AW: registered write address.
- `wr_data` output WIDTH: registered write data.
- `last_grant` output 1: registered; 0 means A was granted most recently, 1 means B was.

## Operation
- Grant logic is combinational from `stall`, `a_valid`, `b_valid` and `last_grant`.
  - `stall`=1: `a_ready`=`b_ready`=0.
  - Only A valid: `a_ready`=1.
  - Only B valid: `b_ready`=1.
  - Both valid: the source not granted last wins. If `last_grant`=1, A wins; otherwise B wins.
  - Neither valid: both readies are 0.
- `a_ready` and `b_ready` are never 1 in the same cycle.
- Ready never depends on the source's own addr or data.
- A transfer occurs on a rising edge where `valid` and `ready` are both 1 for that source.
- On a transfer:
  - `wr_addr` and `wr_data` load the granted source's addr and data.
  - `wr_en` is set to 1, unless addr == `ZERO_REG`, in which case `wr_en` is set to 0.
  - `last_grant` updates to the granted source. This includes zero-register transfers.
- No transfer: `wr_en` is set to 0. `wr_addr`, `wr_data` and `last_grant` hold.
- A source may drop `valid` without a transfer. No state changes in that case.
- Only `wr_en` qualifies the write; the register file must ignore `wr_addr`/`wr_data` when `wr_en`=0.

## Timing
- Latency: a transfer at edge N produces `wr_en`/`wr_addr`/`wr_data` valid during cycle N+1. The register file captures the data at edge N+1.
- Throughput: one write per cycle, with full back-to-back transfers allowed.
- Fairness: under continuous contention, grants alternate A, B, A, B… No source waits more than one transfer while the other is served, excluding `stall` cycles.
- Reset values, after any edge with `reset`=1: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `last_grant`=1, so A wins the first tie.
- `reset` overrides everything:
  - A handshake in the reset cycle is not a transfer.
  - `wr_en` is 0 in the following cycle.
  - Readies still evaluate combinationally during reset, but the sources must treat the transfer as lost.
- `stall` and contention in the same cycle: no grant. The `last_grant` pointer holds, so the same winner is chosen once `stall` drops.

## Test plan
- Reset, then idle: `wr_en`, `wr_addr`, `wr_data` are all 0 and `last_grant`=1. Both readies stay 0 with no valids.
- A alone, addr=3, data=5000: `a_ready`=1 that cycle. Next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=5000, `last_grant`=0. The cycle after that, `wr_en`=0.
- A and B both held valid for 4 cycles (A: addr 1, data 1010; B: addr 2, data 2020): grant order is A, B, A, B. `wr_addr` reads 1, 2, 1, 2 with `wr_en`=1 throughout.
- B writes addr=31: `b_ready`=1, next-cycle `wr_en`=0 and `last_grant`=1. A subsequent A+B tie then grants A.
- Both valid with `stall`=1 for 2 cycles: no readies and `wr_en`=0. On the first cycle after `stall` drops, the grant goes to the side opposite `last_grant`.
- `reset` asserted in the same cycle as an A transfer: next cycle `wr_en`=0, `wr_addr`=0, `last_grant`=1.
